// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer.
//
// Holds a PLL in reset for a fixed pulse, waits for a qualified (stable)
// lock, then releases three downstream reset stages one after another.
// Lock loss or a forced relock while releasing/running restarts the PLL and
// bumps a saturating relock counter. A lock that never arrives retries the
// PLL reset after a timeout without counting it as a relock.
//
// Ports:
//   refclk       free-running reference clock (only clock of this block)
//   rst          asynchronous active-high reset
//   locked       PLL lock indication, asynchronous to refclk
//   force_relock single-cycle request to restart the PLL
//   pll_rst      reset driven into the PLL
//   rst_out[2:0] staged downstream resets, active-high, bit 0 released first
//   ready        all stages released and lock held
//   relock_cnt   saturating count of lock losses and forced relocks
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_LEN    = 16,
  parameter int unsigned LOCK_WAIT      = 4096,
  parameter int unsigned RELOCK_TIMEOUT = 65536,
  parameter int unsigned RST_STAGGER    = 256
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic [2:0] rst_out,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  // One shared counter covers both the PLL reset pulse and the stagger gaps.
  localparam int unsigned CNT_MAX = (PLL_RST_LEN > RST_STAGGER) ? PLL_RST_LEN : RST_STAGGER;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = $clog2(LOCK_WAIT + 1);
  localparam int unsigned TW      = $clog2(RELOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_LEN - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(RST_STAGGER - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(RELOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLLRST,
    S_WAITLOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic            pll_rst_q, pll_rst_d;
  logic [2:0]      rst_out_q, rst_out_d;
  logic            ready_q, ready_d;
  logic [7:0]      relock_q, relock_d;
  logic            sync1_q, locked_s_q;

  logic            go_pllrst;
  logic            bump_relock;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      relock_q  <= relock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    timeout_d   = timeout_q;
    pll_rst_d   = pll_rst_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    relock_d    = relock_q;
    go_pllrst   = 1'b0;
    bump_relock = 1'b0;

    unique case (state_q)
      S_PLLRST: begin
        if (force_relock) begin
          go_pllrst = 1'b1;
        end else if (cnt_q == RST_LAST) begin
          state_d   = S_WAITLOCK;
          cnt_d     = '0;
          stable_d  = '0;
          timeout_d = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAITLOCK: begin
        if (force_relock) begin
          go_pllrst = 1'b1;
        end else begin
          stable_d  = locked_s_q ? stable_q + SW'(1) : '0;
          timeout_d = timeout_q + TW'(1);
          // Lock qualification is tested first so it wins a same-cycle timeout.
          if (locked_s_q && (stable_q == STABLE_LAST)) begin
            state_d      = S_RELEASE;
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            stable_d     = '0;
            timeout_d    = '0;
          end else if (timeout_q == TMO_LAST) begin
            go_pllrst = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        if (!locked_s_q || force_relock) begin
          go_pllrst   = 1'b1;
          bump_relock = 1'b1;
        end else if (cnt_q == STAGGER_LAST) begin
          cnt_d = '0;
          // Stage 1 still asserted means this gap ends stage 1; otherwise stage 2.
          if (rst_out_q[1]) begin
            rst_out_d[1] = 1'b0;
          end else begin
            rst_out_d[2] = 1'b0;
            ready_d      = 1'b1;
            state_d      = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RUN: begin
        if (!locked_s_q || force_relock) begin
          go_pllrst   = 1'b1;
          bump_relock = 1'b1;
        end
      end

      default: begin
        go_pllrst = 1'b1;
      end
    endcase

    if (go_pllrst) begin
      state_d   = S_PLLRST;
      cnt_d     = '0;
      stable_d  = '0;
      timeout_d = '0;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end

    if (bump_relock && (relock_q != '1)) begin
      relock_d = relock_q + 8'd1;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int unsigned LEN = 4;
  localparam int unsigned LW  = 8;
  localparam int unsigned TO  = 64;
  localparam int unsigned S   = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic [7:0] relock_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  pll_lock_sequencer #(
    .PLL_RST_LEN   (LEN),
    .LOCK_WAIT     (LW),
    .RELOCK_TIMEOUT(TO),
    .RST_STAGGER   (S)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .rst_out     (rst_out),
    .ready       (ready),
    .relock_cnt  (relock_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase plus elapsed cycles in that phase; outputs are
  // derived from elapsed time rather than from per-stage flags.
  localparam int P_RST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3;
  int m_phase, m_t, m_stable, m_rel;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_phase = P_RST; m_t = 0; m_stable = 0; m_rel = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_restart(input bit count_it);
    m_phase = P_RST; m_t = 0; m_stable = 0;
    if (count_it) m_rel = (m_rel < 255) ? m_rel + 1 : 255;
  endtask

  task automatic model_edge(input bit l, input bit f);
    bit ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = l;
    case (m_phase)
      P_RST: begin
        if (f) m_t = 0;
        else begin
          m_t++;
          if (m_t == LEN) begin m_phase = P_WAIT; m_t = 0; m_stable = 0; end
        end
      end
      P_WAIT: begin
        if (f) model_restart(0);
        else begin
          m_stable = ls ? m_stable + 1 : 0;
          m_t++;
          if (m_stable == LW) begin m_phase = P_REL; m_t = 0; end
          else if (m_t == TO) model_restart(0);
        end
      end
      default: begin
        if (!ls || f) model_restart(1);
        else begin
          m_t++;
          if (m_phase == P_REL && m_t == 2 * S) m_phase = P_RUN;
        end
      end
    endcase
  endtask

  function automatic logic [2:0] exp_rst_out();
    if (m_phase == P_RST || m_phase == P_WAIT) return 3'b111;
    if (m_phase == P_REL) return {1'b1, (m_t < S) ? 1'b1 : 1'b0, 1'b0};
    return 3'b000;
  endfunction

  task automatic compare_all();
    check("pll_rst", pll_rst, (m_phase == P_RST) ? 1 : 0);
    check("rst_out", rst_out, exp_rst_out());
    check("ready", ready, (m_phase == P_RUN) ? 1 : 0);
    check("relock_cnt", relock_cnt, m_rel);
  endtask

  task automatic cyc(input logic l, input logic f);
    locked = l;
    force_relock = f;
    @(posedge refclk);
    model_edge(l, f);
    @(negedge refclk);
    force_relock = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    force_relock = 1'b0;
    model_reset();
    @(negedge refclk);
    @(negedge refclk);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_rst_out", rst_out, 3'b111);
    check("rst_ready", ready, 0);
    check("rst_relock", relock_cnt, 0);
    rst = 1'b0;
  endtask

  initial begin
    int e_pll, e_r0, e_r1, e_rdy, e_rise, w, n;
    bit tmo, l, f;

    // Normal bring-up with lock arriving after 10 cycles.
    do_reset();
    e_pll = -1; e_r0 = -1; e_r1 = -1; e_rdy = -1;
    for (int e = 1; e <= 40; e++) begin
      cyc(e >= 11, 1'b0);
      if (e_pll < 0 && !pll_rst) e_pll = e;
      if (e_r0 < 0 && !rst_out[0]) e_r0 = e;
      if (e_r1 < 0 && !rst_out[1]) e_r1 = e;
      if (e_rdy < 0 && ready && !rst_out[2]) e_rdy = e;
    end
    check("bringup_pll_fall", e_pll, 4);
    check("bringup_r0_fall", e_r0, 20);
    check("bringup_r1_fall", e_r1, 23);
    check("bringup_ready", e_rdy, 26);

    // One-cycle lock drop while running.
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("loss_rst_out", rst_out, 3'b111);
    check("loss_ready", ready, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_relock", relock_cnt, 1);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0);
    check("relock_ready", ready, 1);

    // Lock never arrives: periodic PLL reset retries.
    do_reset();
    e_rise = -1;
    for (int e = 1; e <= 150; e++) begin
      cyc(1'b0, 1'b0);
      if (e_rise < 0 && e > 4 && pll_rst) e_rise = e;
    end
    check("nolock_retry_edge", e_rise, 68);
    check("nolock_relock", relock_cnt, 0);

    // Lock glitch restarts qualification.
    do_reset();
    e_r0 = -1;
    for (int e = 1; e <= 40; e++) begin
      cyc((e >= 11 && e <= 15) || e >= 17, 1'b0);
      if (e_r0 < 0 && !rst_out[0]) e_r0 = e;
    end
    check("glitch_r0_fall", e_r0, 26);

    // Forced relocks until saturation, then a force during lock wait.
    do_reset();
    tmo = 0;
    for (int k = 0; k < 260; k++) begin
      w = 0;
      while (!ready && w < 100) begin cyc(1'b1, 1'b0); w++; end
      if (!ready) tmo = 1;
      cyc(1'b1, 1'b1);
    end
    check("sat_wait_timeouts", tmo, 0);
    check("sat_relock", relock_cnt, 255);
    w = 0;
    while (!(pll_rst == 1'b0 && rst_out == 3'b111) && w < 20) begin cyc(1'b1, 1'b0); w++; end
    check("reach_waitlock", {pll_rst, rst_out}, 4'b0111);
    cyc(1'b1, 1'b1);
    n = 0;
    while (pll_rst && n < 20) begin n++; cyc(1'b1, 1'b0); end
    check("force_wait_len", n, 4);
    check("force_wait_relock", relock_cnt, 255);

    // Randomized lock behaviour and occasional forces.
    do_reset();
    l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) l = !l;
      f = ($urandom_range(0, 149) == 0);
      cyc(l, f);
    end

    // Asynchronous reset in the middle of the release sequence.
    do_reset();
    w = 0;
    while (rst_out != 3'b110 && w < 40) begin cyc(1'b1, 1'b0); w++; end
    check("async_reach_release", rst_out, 3'b110);
    #2 rst = 1'b1;
    #1;
    check("async_pll_rst", pll_rst, 1);
    check("async_rst_out", rst_out, 3'b111);
    check("async_ready", ready, 0);
    check("async_relock", relock_cnt, 0);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The parameter PLL_RST_LEN SHALL default to 16 and SHALL set the number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 The parameter LOCK_WAIT SHALL default to 4096 and SHALL set the number of consecutive cycles with synchronized locked high required before releasing resets.
REQ-003 The parameter RELOCK_TIMEOUT SHALL default to 65536 and SHALL set the maximum cycles spent waiting for lock before the PLL is reset again.
REQ-004 The parameter RST_STAGGER SHALL default to 256 and SHALL set the number of cycles between successive reset-stage releases.
REQ-005 The port refclk SHALL be an input, 1 bit: the free-running reference clock, never a PLL output; it is the block's only clock.
REQ-006 The port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-007 The port locked SHALL be an input, 1 bit: the PLL lock indication, asynchronous to refclk.
REQ-008 The port force_relock SHALL be an input, 1 bit: a single-cycle request to restart the PLL.
REQ-009 The port pll_rst SHALL be an output, 1 bit: the reset that drives the PLL rst input.
REQ-010 The port rst_out SHALL be an output, 3 bits: staged downstream resets, active-high; bit 0 is released first.
REQ-011 The port ready SHALL be an output, 1 bit: high when all stages are released and lock is held.
REQ-012 The port relock_cnt SHALL be an output, 8 bits: a saturating count of lock losses and forced relocks.

Function
REQ-013 The locked input SHALL pass through a 2-flop synchronizer to form locked_s, a 2-cycle latency; all decisions SHALL use locked_s.
REQ-014 The state machine SHALL have the states PLLRST, WAITLOCK, RELEASE and RUN, and all outputs SHALL be registered.
REQ-015 PLLRST: pll_rst=1 and rst_out=3'b111 for exactly PLL_RST_LEN cycles, then go to WAITLOCK with pll_rst=0.
REQ-016 WAITLOCK: the stable counter SHALL increment while locked_s=1 and clear whenever locked_s=0; the timeout counter SHALL increment every cycle.
REQ-017 WAITLOCK: when the stable counter reaches LOCK_WAIT, go to RELEASE and drive rst_out[0]=0 on the same edge.
REQ-018 WAITLOCK: when the timeout counter reaches RELOCK_TIMEOUT without lock, go to PLLRST and clear both counters; relock_cnt SHALL NOT change.
REQ-019 If lock qualification and timeout occur on the same cycle, lock qualification SHALL win.
REQ-020 RELEASE: rst_out[1] SHALL fall RST_STAGGER cycles after rst_out[0], and rst_out[2] SHALL fall RST_STAGGER cycles after that, on the same edge that enters RUN and sets ready=1.
REQ-021 RELEASE or RUN, on locked_s=0 or force_relock=1: on the next edge, drive rst_out=3'b111, ready=0 and pll_rst=1, enter PLLRST with the counter at 0, and increment relock_cnt.
REQ-022 relock_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-023 force_relock in PLLRST or WAITLOCK SHALL restart PLLRST from count 0 without incrementing relock_cnt.
REQ-024 Counter widths SHALL be sized from the parameters and SHALL NOT wrap before their terminal values.

Reset
REQ-025 While rst=1, regardless of clock, the block SHALL hold: state=PLLRST, pll_rst=1, rst_out=3'b111, ready=0, relock_cnt=0, all counters=0, synchronizer flops=0.
REQ-026 Release of rst SHALL take effect on the first refclk edge and begin a full PLL_RST_LEN pulse.
REQ-027 Asserting rst mid-sequence SHALL abort immediately to the reset values of REQ-025.

Verification (PLL_RST_LEN=4, LOCK_WAIT=8, RELOCK_TIMEOUT=64, RST_STAGGER=3)
REQ-028 Normal bring-up: deassert rst, raise locked after 10 cycles -> pll_rst high for 4 cycles; rst_out[0] falls 10 (locked edge) +2 (sync) +8 cycles after the start; bit 1 falls +3 cycles later; bit 2 and ready rise +3 cycles after that.
REQ-029 Lock never asserts -> pll_rst re-pulses for 4 cycles every 4+64 cycles; relock_cnt stays 0.
REQ-030 Lock glitch: locked high for 5 cycles, low for 1, then high -> the stable count restarts; release occurs 8 cycles after the final rise plus sync latency.
REQ-031 Lock loss in RUN: drop locked for 1 cycle -> 2 cycles later rst_out=3'b111, ready=0, pll_rst=1, relock_cnt=1; the full sequence repeats.
REQ-032 Saturation and force: 260 force_relock pulses, each issued in RUN -> relock_cnt=255; a force_relock during WAITLOCK restarts pll_rst for 4 cycles and leaves the count at 255.
REQ-033 Async reset mid-RELEASE (rst_out=3'b110) -> all outputs return to their reset values without a clock edge.
